// File: rtl/mnist_job_sched_pkg.sv
// mnist_pkg: shared constants and scheduler state encoding for the MNIST job scheduler.
package mnist_pkg;
    localparam int IMG_BITS = 6272;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ERR_DIGIT = 4'hF;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} sched_state_t;
endpackage

// File: rtl/mnist_job_sched_if.sv
// mnist_job_sched_if: host-side request/response bundle; master = requesters, slave = scheduler.
interface mnist_job_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int IMG_BITS = mnist_pkg::IMG_BITS
);
    import mnist_pkg::*;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*IMG_BITS-1:0] req_img;
    logic [NUM_REQ-1:0] resp_valid;
    logic [NUM_REQ-1:0] resp_ready;
    logic [DIGIT_W-1:0] resp_digit;
    logic resp_err;
    modport master(output req_valid, req_img, resp_ready, input req_ready, resp_valid, resp_digit, resp_err);
    modport slave(input req_valid, req_img, resp_ready, output req_ready, resp_valid, resp_digit, resp_err);
endinterface

// File: rtl/mnist_job_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from ptr with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    logic [2*NUM_REQ-1:0] rot;
    assign rot = {req, req} >> ptr;
    // Scan downward so the smallest offset from ptr is assigned last and wins.
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) idx = $clog2(NUM_REQ)'((int'(ptr) + i) % NUM_REQ);
        gnt = (|req) ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/mnist_job_sched.sv
// mnist_job_sched: shares one inference engine among NUM_REQ requesters with
// round-robin arbitration, image buffering, start/done sequencing and a watchdog.
module mnist_job_sched #(
    parameter int NUM_REQ = 4,
    parameter int IMG_BITS = mnist_pkg::IMG_BITS,
    parameter int TIMEOUT_CYC = 2048,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mnist_job_sched_if.slave     bus,
    output logic                 acc_start,
    output logic [IMG_BITS-1:0]  acc_img,
    input  logic                 acc_done,
    input  logic [3:0]           acc_pred,
    output logic                 busy,
    output logic [CNT_W-1:0]     job_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    import mnist_pkg::*;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    sched_state_t state;
    logic [IDX_W-1:0] ptr, gnt, win_idx;
    logic [NUM_REQ-1:0] win;
    logic [TW-1:0] cnt;
    logic [IMG_BITS-1:0] img_buf;
    logic timeout;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.req_valid), .ptr(ptr), .gnt(win), .idx(win_idx));
    assign bus.req_ready = (state == IDLE) ? win : '0;
    assign acc_img = img_buf;
    assign timeout = (TIMEOUT_CYC != 0) && (cnt == TW'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            gnt <= '0;
            cnt <= '0;
            img_buf <= '0;
            acc_start <= 1'b0;
            busy <= 1'b0;
            bus.resp_valid <= '0;
            bus.resp_digit <= '0;
            bus.resp_err <= 1'b0;
            job_cnt <= '0;
            err_cnt <= '0;
        end else begin
            acc_start <= 1'b0;
            case (state)
                IDLE: if (|bus.req_valid) begin
                    img_buf <= bus.req_img[win_idx*IMG_BITS +: IMG_BITS];
                    gnt <= win_idx;
                    acc_start <= 1'b1;
                    busy <= 1'b1;
                    state <= START;
                end
                START: begin
                    cnt <= '0;
                    state <= WAIT;
                end
                // A done arriving on the timeout cycle still returns the real result.
                WAIT: if (acc_done || timeout) begin
                    bus.resp_digit <= acc_done ? acc_pred : ERR_DIGIT;
                    bus.resp_err <= !acc_done;
                    bus.resp_valid <= NUM_REQ'(1) << gnt;
                    state <= RESP;
                end else cnt <= cnt + 1'b1;
                RESP: if (bus.resp_ready[gnt]) begin
                    ptr <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
                    job_cnt <= job_cnt + 1'b1;
                    err_cnt <= err_cnt + CNT_W'(bus.resp_err && !(&err_cnt));
                    bus.resp_valid <= '0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mnist_job_sched.sv
// tb_mnist_job_sched: randomized bench with a transaction-level scheduler model and engine stub.
module tb_mnist_job_sched;
    import mnist_pkg::*;
    localparam int N = 4;
    localparam int IB = IMG_BITS;
    localparam int TO = 1000;
    localparam int CW = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic acc_start, busy;
    logic acc_done = 1'b0;
    logic [3:0] acc_pred = 4'd0;
    logic [IB-1:0] acc_img;
    logic [CW-1:0] job_cnt, err_cnt;
    mnist_job_sched_if #(.NUM_REQ(N), .IMG_BITS(IB)) bus ();
    mnist_job_sched #(.NUM_REQ(N), .IMG_BITS(IB), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .acc_start(acc_start), .acc_img(acc_img),
        .acc_done(acc_done), .acc_pred(acc_pred), .busy(busy), .job_cnt(job_cnt), .err_cnt(err_cnt));
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [IB-1:0] imgs [N];
    int ord [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_img(input string name, input logic [IB-1:0] act, input logic [IB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int o = 0; o < N; o++) if (v[(p + o) % N]) return (p + o) % N;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Engine stub: done pulses lat cycles into WAIT (lat=0 never answers).
    int cd = -1, lat = 3;
    logic [3:0] pred = 4'd0;
    bit noise = 0, rnd = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            acc_done = 1'b0;
            cd = -1;
        end else if (acc_start) begin
            if (rnd) begin
                lat = int'($urandom_range(1, 40));
                pred = 4'($urandom_range(0, 9));
            end
            cd = lat;
            acc_done = noise && ($urandom_range(0, 1) == 1);
        end else if (cd > 0) begin
            cd--;
            acc_done = (cd == 0);
        end else acc_done = noise && ($urandom_range(0, 3) == 0);
        acc_pred = acc_done ? pred : 4'($urandom);
    end

    // Reference model: job lifetime tracked as age since accept.
    bit m_job = 0, m_has = 0, m_err = 0;
    int m_age = 0, m_gnt = 0, m_ptr = 0, m_jobs = 0, m_errs = 0;
    logic [3:0] m_dig = 4'd0;
    logic [IB-1:0] m_img = '0;
    always @(negedge clk) begin
        int w;
        if (!rst_n) begin
            m_job = 0; m_has = 0; m_err = 0; m_age = 0; m_gnt = 0; m_ptr = 0;
            m_jobs = 0; m_errs = 0; m_dig = 4'd0; m_img = '0;
        end
        w = pick(bus.req_valid, m_ptr);
        chk("busy", 64'(busy), 64'(m_job));
        chk("req_ready", 64'(bus.req_ready), (!m_job && rst_n && w >= 0) ? 64'(1) << w : 64'(0));
        chk("acc_start", 64'(acc_start), 64'(m_job && m_age == 1));
        chk("resp_valid", 64'(bus.resp_valid), m_has ? 64'(1) << m_gnt : 64'(0));
        if (m_has || !rst_n) begin
            chk("resp_digit", 64'(bus.resp_digit), 64'(m_dig));
            chk("resp_err", 64'(bus.resp_err), 64'(m_err));
        end
        chk_img("acc_img", acc_img, m_img);
        chk("job_cnt", 64'(job_cnt), 64'(m_jobs[15:0]));
        chk("err_cnt", 64'(err_cnt), 64'(m_errs));
        if (rst_n) begin
            if (!m_job) begin
                if (w >= 0) begin
                    m_job = 1; m_age = 1; m_has = 0; m_gnt = w;
                    m_img = bus.req_img[w*IB +: IB];
                end
            end else if (m_has) begin
                if (bus.resp_ready[m_gnt]) begin
                    m_job = 0; m_has = 0; m_ptr = (m_gnt + 1) % N; m_jobs++;
                    if (m_err && m_errs < 65535) m_errs++;
                end
            end else begin
                if (m_age >= 2) begin
                    if (acc_done === 1'b1) begin
                        m_has = 1; m_dig = acc_pred; m_err = 0;
                    end else if (m_age - 2 == TO - 1) begin
                        m_has = 1; m_dig = 4'hF; m_err = 1;
                    end
                end
                m_age++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_img(input int k);
        for (int i = 0; i < IB / 32; i++) imgs[k][i*32 +: 32] = $urandom;
        bus.req_img[k*IB +: IB] = imgs[k];
    endtask

    task automatic wait_resp(input int bound, output int n);
        n = 0;
        while (bus.resp_valid == '0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("resp_arrived", 64'(n < bound), 64'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, g;
        logic [3:0] d0;
        logic [IB-1:0] old;
        bus.req_valid = '0;
        bus.resp_ready = '0;
        bus.req_img = '0;
        for (int k = 0; k < N; k++) new_img(k);
        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_jobs", 64'(job_cnt), 64'(0));
        rst_n = 1'b1;

        // single request on port 2, 800-cycle inference
        lat = 800; pred = 4'd7;
        step(); bus.req_valid = 4'b0100;
        @(negedge clk); chk("t1_ready", 64'(bus.req_ready), 64'(4'b0100));
        step(); bus.req_valid = '0;
        @(negedge clk); chk("t1_start", 64'(acc_start), 64'(1));
        wait_resp(TO + 10, n);
        chk("t1_valid", 64'(bus.resp_valid), 64'(4'b0100));
        chk("t1_digit", 64'(bus.resp_digit), 64'(7));
        chk("t1_err", 64'(bus.resp_err), 64'(0));
        step(); bus.resp_ready = 4'b0100;
        @(negedge clk);
        @(negedge clk); chk("t1_jobs", 64'(job_cnt), 64'(1));
        step(); bus.resp_ready = '0;

        // all ports requesting from ptr 0
        do_reset();
        lat = 3; pred = 4'd2;
        bus.resp_ready = '1;
        bus.req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            @(negedge clk);
            while (bus.req_ready == '0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            g = oh_idx(bus.req_ready);
            chk("t2_order", 64'(g), 64'(ord[j]));
            @(negedge clk);
            if (g >= 0) chk_img("t2_img", acc_img, imgs[g]);
        end
        step(); bus.req_valid = '0;
        wait_idle();

        // image change after accept must not leak into the buffer
        step(); bus.req_valid = 4'b0010;
        step(); bus.req_valid = '0; old = imgs[1]; new_img(1);
        @(negedge clk); chk_img("t3_start", acc_img, old);
        wait_idle(); chk_img("t3_idle", acc_img, old);
        step(); bus.req_valid = 4'b0010;
        step(); bus.req_valid = '0;
        @(negedge clk); chk_img("t3_new", acc_img, imgs[1]);
        wait_idle();

        // watchdog expiry, then done coinciding with the timeout cycle
        bus.resp_ready = '0;
        for (int t = 0; t < 2; t++) begin
            lat = (t == 0) ? 0 : TO; pred = 4'd5;
            step(); bus.req_valid = 4'b0001;
            step(); bus.req_valid = '0;
            @(negedge clk);
            wait_resp(TO + 20, n);
            chk("t4_latency", 64'(n), 64'(TO + 1));
            chk("t4_digit", 64'(bus.resp_digit), (t == 0) ? 64'(4'hF) : 64'(5));
            chk("t4_err", 64'(bus.resp_err), (t == 0) ? 64'(1) : 64'(0));
            step(); bus.resp_ready = 4'b0001;
            @(negedge clk);
            @(negedge clk); chk("t4_errcnt", 64'(err_cnt), 64'(1));
            step(); bus.resp_ready = '0;
        end

        // held-off response with stray ready on other ports
        lat = 3; pred = 4'd9;
        step(); bus.req_valid = 4'b1000;
        step(); bus.req_valid = 4'b0111;
        wait_resp(50, n);
        d0 = bus.resp_digit;
        for (int c = 0; c < 50; c++) begin
            step(); bus.resp_ready = 4'($urandom) & 4'b0111;
            @(negedge clk);
            chk("t5_valid", 64'(bus.resp_valid), 64'(4'b1000));
            chk("t5_digit", 64'(bus.resp_digit), 64'(d0));
            chk("t5_ready", 64'(bus.req_ready), 64'(0));
            chk("t5_start", 64'(acc_start), 64'(0));
        end
        step(); bus.resp_ready = 4'b1000;
        @(negedge clk);
        @(negedge clk); chk("t5_next", 64'(bus.req_ready), 64'(4'b0001));
        step(); bus.req_valid = '0; bus.resp_ready = '1;
        wait_idle();

        // asynchronous reset while waiting on a hung engine
        lat = 0; bus.resp_ready = '0;
        step(); bus.req_valid = 4'b0100;
        step(); bus.req_valid = '0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_start", 64'(acc_start), 64'(0));
        chk("t6_valid", 64'(bus.resp_valid), 64'(0));
        chk_img("t6_img", acc_img, '0);
        chk("t6_jobs", 64'(job_cnt), 64'(0));
        chk("t6_errs", 64'(err_cnt), 64'(0));
        lat = 3;
        step();
        step(); rst_n = 1'b1; bus.req_valid = '1;
        @(negedge clk); chk("t6_ptr0", 64'(bus.req_ready), 64'(4'b0001));
        step(); bus.req_valid = '0; bus.resp_ready = '1;
        wait_idle();

        // randomized traffic
        rnd = 1; noise = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.req_valid = 4'($urandom);
            bus.resp_ready = 4'($urandom);
            if ($urandom_range(0, 3) == 0) new_img(int'($urandom_range(0, N - 1)));
        end
        step(); bus.req_valid = '0; bus.resp_ready = '1; noise = 0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
